multicycle_control_fsm: RTL
===========================

Name: multicycle_control_fsm

Overview:
- Moore-style control FSM for the multicycle MIPS datapath. Sequences one instruction over 3–5 cycles on a shared instruction/data memory.
- Drives PC, IR, register-file, ALU-source and memory enables each cycle.
- Supports wait states on memory (mem_ready handshake), a bounded-wait fault, and a retired-instruction counter.
- Sits between the IR opcode field and the datapath muxes/enables.

Parameters:
- COUNT_W, 32, width of the retired-instruction counter.
- WAIT_MAX, 15, max cycles waiting for mem_ready before a fault; 0 disables the timeout.

Ports:
- clk  in  1  rising-edge clock
- nrst  in  1  reset, synchronous, active-low
- opcode  in  6  IR[31:26]; stable from DECODE until next FETCH
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if branch condition holds
- branch_ne  out  1  1=BNE condition (zero==0), 0=BEQ (zero==1)
- pc_src  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target
- iord  out  1  memory address: 0 PC, 1 ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  load IR
- reg_write  out  1  register-file write enable
- reg_dst  out  1  0 rt, 1 rd
- mem_to_reg  out  1  0 ALUOut, 1 MDR
- alu_src_a  out  1  0 PC, 1 reg A
- alu_src_b  out  2  00 reg B, 01 const 4, 10 imm, 11 sign-ext imm<<2
- imm_zext  out  1  zero-extend immediate (ANDI/ORI)
- alu_op  out  3  000 ADD, 001 SUB, 010 FUNCT, 011 AND, 100 OR, 101 SLT
- illegal  out  1  one-cycle pulse on unknown opcode
- mem_fault  out  1  one-cycle pulse on memory wait timeout
- state  out  4  current state encoding, for debug
- instr_count  out  COUNT_W  retired instructions; wraps modulo 2^COUNT_W

Behaviour:
- Reset:
  - nrst low at a clock edge sets state=FETCH(0), instr_count=0 and wait counter=0.
  - While nrst=0, every enable/pulse output is forced to 0 (pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write, illegal, mem_fault). Selects take their FETCH values.
  - A reset in any state aborts the instruction without counting it.
- Outputs are decoded from the registered state; unlisted signals are 0 in every state.
- Encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXEC_R 6, R_WB 7, EXEC_I 8, I_WB 9, BRANCH 10, JUMP 11. Codes 12–15 go to FETCH.
- FETCH:
  - Outputs: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, ADD, pc_src=00.
  - ir_write = pc_write = mem_ready.
  - mem_ready=1 goes to DECODE; otherwise stay.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, ADD.
  - Next state by opcode:
    - 000000 → EXEC_R
    - LW 100011, SW 101011 → MEM_ADDR
    - ADDI 001000, ADDIU 001001, ANDI 001100, ORI 001101, SLTI 001010 → EXEC_I
    - BEQ 000100, BNE 000101 → BRANCH
    - J 000010 → JUMP
    - anything else → FETCH with illegal=1 this cycle; the instruction is not counted.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, ADD. Goes to MEM_READ if LW, MEM_WRITE if SW.
- MEM_READ: mem_read=1, iord=1; mem_ready goes to MEM_WB, else stay.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1; goes to FETCH.
- MEM_WRITE: mem_write=1, iord=1; mem_ready goes to FETCH, else stay.
- EXEC_R: alu_src_a=1, alu_src_b=00, FUNCT; goes to R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0; goes to FETCH.
- EXEC_I:
  - Outputs: alu_src_a=1, alu_src_b=10.
  - alu_op: ADD for ADDI/ADDIU, AND+imm_zext for ANDI, OR+imm_zext for ORI, SLT for SLTI.
  - Goes to I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0; goes to FETCH.
- BRANCH:
  - Outputs: alu_src_a=1, alu_src_b=00, SUB, pc_write_cond=1, pc_src=01.
  - branch_ne=1 iff opcode=BNE.
  - Goes to FETCH.
- JUMP: pc_write=1, pc_src=10; goes to FETCH.
- Retire: instr_count increments by 1 on each transition into FETCH from MEM_WB, MEM_WRITE (with mem_ready), R_WB, I_WB, BRANCH or JUMP.
- Latency per instruction, no wait states: R/I-type 4, LW 5, SW 4, BEQ/BNE 3, J 3 cycles.
- Wait timeout:
  - The wait counter clears on entry to FETCH, MEM_READ and MEM_WRITE, and increments each cycle the state holds with mem_ready=0.
  - When WAIT_MAX≠0 and the counter reaches WAIT_MAX with mem_ready=0: mem_fault=1 for that cycle and state goes to FETCH (from FETCH, re-enters FETCH with the counter cleared).
  - The aborted instruction is not counted.
  - mem_ready=1 in the same cycle as the timeout takes priority: normal transition, no fault.

Test Plan:
- Reset: hold nrst=0 for 3 cycles in MEM_READ → state=0, instr_count=0, all enables 0; release → FETCH mem_read=1.
- R-type: opcode 000000, mem_ready=1 always → states 0,1,6,7,0; reg_write=1 with reg_dst=1 only in R_WB; instr_count 0→1.
- LW with 2 wait cycles: fetch ready, then mem_ready=0,0,1 in MEM_READ → states 0,1,2,3,3,3,4,0; iord=1 throughout MEM_READ; mem_to_reg=1 in MEM_WB.
- BNE (000101) then ORI (001101) → BRANCH shows pc_write_cond=1, branch_ne=1, alu_op=001; EXEC_I shows alu_op=100, imm_zext=1; instr_count +2.
- Illegal opcode 111111 → DECODE asserts illegal for 1 cycle, next state FETCH, instr_count unchanged.
- Timeout with WAIT_MAX=15: SW with mem_ready held 0 → mem_fault pulses on the 15th wait cycle, state→0, count unchanged. Repeat with mem_ready=1 on that cycle → no fault, count +1.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Control sequencer for the multicycle MIPS datapath: walks each instruction through
// fetch/decode/execute/writeback states, with memory wait states and a bounded-wait fault.
module multicycle_control_fsm #(
    parameter int COUNT_W  = 32,
    parameter int WAIT_MAX = 15
) (
    input  logic               i_clk,
    input  logic               i_nrst,
    input  logic [5:0]         i_opcode,
    input  logic               i_mem_ready,
    output logic               o_pc_write,
    output logic               o_pc_write_cond,
    output logic               o_branch_ne,
    output logic [1:0]         o_pc_src,
    output logic               o_iord,
    output logic               o_mem_read,
    output logic               o_mem_write,
    output logic               o_ir_write,
    output logic               o_reg_write,
    output logic               o_reg_dst,
    output logic               o_mem_to_reg,
    output logic               o_alu_src_a,
    output logic [1:0]         o_alu_src_b,
    output logic               o_imm_zext,
    output logic [2:0]         o_alu_op,
    output logic               o_illegal,
    output logic               o_mem_fault,
    output logic [3:0]         o_state,
    output logic [COUNT_W-1:0] o_instr_count
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_R_WB      = 4'd7,
        S_EXEC_I    = 4'd8,
        S_I_WB      = 4'd9,
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;
    localparam logic [2:0] ALU_SLT   = 3'b101;

    localparam int WAIT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
    // Counter holds the number of stalled cycles already spent, so the fault fires
    // on the WAIT_MAX-th stalled cycle.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((WAIT_MAX == 0) ? 0 : WAIT_MAX - 1);

    state_t               r_state;
    logic [WAIT_W-1:0]    r_wait_cnt;
    logic [COUNT_W-1:0]   r_instr_count;

    logic   w_waiting;
    logic   w_timeout;
    logic   w_retire;
    state_t w_dec_state;

    assign w_waiting = (r_state == S_FETCH) || (r_state == S_MEM_READ) || (r_state == S_MEM_WRITE);
    assign w_timeout = (WAIT_MAX != 0) && w_waiting && !i_mem_ready && (r_wait_cnt == WAIT_LAST);
    assign w_retire  = (r_state == S_MEM_WB) || (r_state == S_R_WB) || (r_state == S_I_WB) ||
                       (r_state == S_BRANCH) || (r_state == S_JUMP) ||
                       ((r_state == S_MEM_WRITE) && i_mem_ready);

    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            r_state       <= S_FETCH;
            r_wait_cnt    <= '0;
            r_instr_count <= '0;
        end else begin
            if (w_retire) begin
                r_instr_count <= r_instr_count + 1'b1;
            end
            // Non-waiting states always leave, so clearing here covers every state entry.
            if (w_waiting && !i_mem_ready && !w_timeout) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end else begin
                r_wait_cnt <= '0;
            end
            case (r_state)
                S_FETCH: begin
                    if (i_mem_ready) r_state <= S_DECODE;
                    else             r_state <= S_FETCH;
                end
                S_DECODE: begin
                    case (i_opcode)
                        OP_RTYPE:                                   r_state <= S_EXEC_R;
                        OP_LW, OP_SW:                               r_state <= S_MEM_ADDR;
                        OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_SLTI: r_state <= S_EXEC_I;
                        OP_BEQ, OP_BNE:                             r_state <= S_BRANCH;
                        OP_J:                                       r_state <= S_JUMP;
                        default:                                    r_state <= S_FETCH;
                    endcase
                end
                S_MEM_ADDR: begin
                    if (i_opcode == OP_LW)      r_state <= S_MEM_READ;
                    else if (i_opcode == OP_SW) r_state <= S_MEM_WRITE;
                    else                        r_state <= S_FETCH;
                end
                S_MEM_READ: begin
                    if (i_mem_ready)    r_state <= S_MEM_WB;
                    else if (w_timeout) r_state <= S_FETCH;
                    else                r_state <= S_MEM_READ;
                end
                S_MEM_WRITE: begin
                    if (i_mem_ready || w_timeout) r_state <= S_FETCH;
                    else                          r_state <= S_MEM_WRITE;
                end
                S_EXEC_R: r_state <= S_R_WB;
                S_EXEC_I: r_state <= S_I_WB;
                default:  r_state <= S_FETCH;
            endcase
        end
    end

    // While in reset the decode behaves as FETCH so the selects are defined.
    assign w_dec_state = i_nrst ? r_state : S_FETCH;

    always_comb begin
        o_pc_write      = 1'b0;
        o_pc_write_cond = 1'b0;
        o_branch_ne     = 1'b0;
        o_pc_src        = 2'b00;
        o_iord          = 1'b0;
        o_mem_read      = 1'b0;
        o_mem_write     = 1'b0;
        o_ir_write      = 1'b0;
        o_reg_write     = 1'b0;
        o_reg_dst       = 1'b0;
        o_mem_to_reg    = 1'b0;
        o_alu_src_a     = 1'b0;
        o_alu_src_b     = 2'b00;
        o_imm_zext      = 1'b0;
        o_alu_op        = ALU_ADD;
        o_illegal       = 1'b0;
        o_mem_fault     = w_timeout;
        case (w_dec_state)
            S_FETCH: begin
                o_mem_read  = 1'b1;
                o_alu_src_b = 2'b01;
                o_ir_write  = i_mem_ready;
                o_pc_write  = i_mem_ready;
            end
            S_DECODE: begin
                o_alu_src_b = 2'b11;
                o_illegal   = !(i_opcode inside {OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_ADDIU, OP_ANDI,
                                                 OP_ORI, OP_SLTI, OP_BEQ, OP_BNE, OP_J});
            end
            S_MEM_ADDR: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = 2'b10;
            end
            S_MEM_READ: begin
                o_mem_read = 1'b1;
                o_iord     = 1'b1;
            end
            S_MEM_WB: begin
                o_reg_write  = 1'b1;
                o_mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                o_mem_write = 1'b1;
                o_iord      = 1'b1;
            end
            S_EXEC_R: begin
                o_alu_src_a = 1'b1;
                o_alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                o_reg_write = 1'b1;
                o_reg_dst   = 1'b1;
            end
            S_EXEC_I: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = 2'b10;
                case (i_opcode)
                    OP_ANDI: begin o_alu_op = ALU_AND; o_imm_zext = 1'b1; end
                    OP_ORI:  begin o_alu_op = ALU_OR;  o_imm_zext = 1'b1; end
                    OP_SLTI: o_alu_op = ALU_SLT;
                    default: o_alu_op = ALU_ADD;
                endcase
            end
            S_I_WB: o_reg_write = 1'b1;
            S_BRANCH: begin
                o_alu_src_a     = 1'b1;
                o_alu_op        = ALU_SUB;
                o_pc_write_cond = 1'b1;
                o_pc_src        = 2'b01;
                o_branch_ne     = (i_opcode == OP_BNE);
            end
            S_JUMP: begin
                o_pc_write = 1'b1;
                o_pc_src   = 2'b10;
            end
            default: ;
        endcase
        if (!i_nrst) begin
            o_pc_write      = 1'b0;
            o_pc_write_cond = 1'b0;
            o_mem_read      = 1'b0;
            o_mem_write     = 1'b0;
            o_ir_write      = 1'b0;
            o_reg_write     = 1'b0;
            o_illegal       = 1'b0;
            o_mem_fault     = 1'b0;
        end
    end

    assign o_state       = r_state;
    assign o_instr_count = r_instr_count;

endmodule
